// File: rtl/sti_dac_gen.sv
// sti_dac_gen: serializes 8..32-bit frames and packs the bit stream into bytes written to odd/even bank pairs.
// Define STI_DAC_GEN_PAD_EN to zero-fill the remaining memory after the last frame before finishing.
module sti_dac_gen #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [15:0]          pi_data,
    input  logic [1:0]           pi_length,
    input  logic                 pi_fill,
    input  logic                 pi_msb,
    input  logic                 pi_low,
    input  logic                 pi_end,
    output logic                 so_data,
    output logic                 so_valid,
    output logic                 busy,
    output logic [7:0]           oem_dataout,
    output logic [ADDR_W-1:0]    oem_addr,
    output logic [NUM_BANKS-1:0] odd_wr,
    output logic [NUM_BANKS-1:0] even_wr,
    output logic                 oem_finish
);
    localparam int CAP = NUM_BANKS << (ADDR_W + 1);
    localparam int KW  = ($clog2(CAP) + 1 < 4) ? 4 : $clog2(CAP) + 1;
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [KW-1:0] CAP_K = KW'(CAP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef STI_DAC_GEN_PAD_EN
        PAD    = 2'd2,
`endif
        FINISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          frame_q, frame_d, frame_in;
    logic [1:0]           len_q, len_d;
    logic                 msb_q, msb_d, end_q, end_d;
    logic [4:0]           cnt_q, cnt_d, nxt, idx;
    logic                 so_data_q, so_data_d;
    logic [6:0]           byte_q, byte_d;
    logic [2:0]           bc_q, bc_d;
    logic [KW-1:0]        k_q, k_d;
    logic [7:0]           dout_q, dout_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [NUM_BANKS-1:0] odd_q, odd_d, even_q, even_d, sel;
    logic                 fin_q, fin_d;
    logic                 last, shift_st, pad_st, wr_en;

    assign frame_in = (pi_length == 2'b00) ? {24'd0, pi_low ? pi_data[15:8] : pi_data[7:0]} :
                      (!pi_fill || pi_length == 2'b01) ? {16'd0, pi_data} :
                      (pi_length == 2'b10) ? {8'd0, pi_data, 8'd0} : {pi_data, 16'd0};

    assign nxt      = cnt_q + 5'd1;
    assign idx      = msb_q ? {len_q, 3'b111} - nxt : nxt;
    assign last     = cnt_q == {len_q, 3'b111};
    assign shift_st = state_q == SHIFT;
`ifdef STI_DAC_GEN_PAD_EN
    assign pad_st   = state_q == PAD;
`else
    assign pad_st   = 1'b0;
`endif
    // Saturated k discards bytes; the serial side keeps running regardless.
    assign wr_en    = ((shift_st && bc_q == 3'd7) || pad_st) && k_q != CAP_K;
    assign sel      = NUM_BANKS'(1) << k_q[ADDR_W+1 +: BW];

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        len_d     = len_q;
        msb_d     = msb_q;
        end_d     = end_q;
        cnt_d     = cnt_q;
        so_data_d = so_data_q;
        byte_d    = byte_q;
        bc_d      = bc_q;
        k_d       = k_q;
        dout_d    = dout_q;
        addr_d    = addr_q;
        odd_d     = '0;
        even_d    = '0;
        fin_d     = fin_q || state_q == FINISH;
        if (wr_en) begin
            k_d              = k_q + KW'(1);
            dout_d           = pad_st ? 8'd0 : {byte_q, so_data_q};
            addr_d           = k_q[ADDR_W:1];
            {odd_d, even_d}  = (k_q[0] ^ k_q[3]) ? {{NUM_BANKS{1'b0}}, sel} : {sel, {NUM_BANKS{1'b0}}};
        end
        if (shift_st) begin
            cnt_d  = nxt;
            byte_d = {byte_q[5:0], so_data_q};
            bc_d   = bc_q + 3'd1;
        end
        case (state_q)
            IDLE: if (load) begin
                state_d   = SHIFT;
                frame_d   = frame_in;
                len_d     = pi_length;
                msb_d     = pi_msb;
                end_d     = pi_end;
                cnt_d     = 5'd0;
                so_data_d = pi_msb ? frame_in[{pi_length, 3'b111}] : frame_in[0];
            end
            SHIFT: begin
                so_data_d = last ? so_data_q : frame_q[idx];
`ifdef STI_DAC_GEN_PAD_EN
                if (last) state_d = !end_q ? IDLE : (k_d == CAP_K) ? FINISH : PAD;
`else
                if (last) state_d = !end_q ? IDLE : FINISH;
`endif
            end
`ifdef STI_DAC_GEN_PAD_EN
            PAD: if (k_d == CAP_K) state_d = FINISH;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            len_q     <= '0;
            msb_q     <= 1'b0;
            end_q     <= 1'b0;
            cnt_q     <= '0;
            so_data_q <= 1'b0;
            byte_q    <= '0;
            bc_q      <= '0;
            k_q       <= '0;
            dout_q    <= '0;
            addr_q    <= '0;
            odd_q     <= '0;
            even_q    <= '0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            len_q     <= len_d;
            msb_q     <= msb_d;
            end_q     <= end_d;
            cnt_q     <= cnt_d;
            so_data_q <= so_data_d;
            byte_q    <= byte_d;
            bc_q      <= bc_d;
            k_q       <= k_d;
            dout_q    <= dout_d;
            addr_q    <= addr_d;
            odd_q     <= odd_d;
            even_q    <= even_d;
            fin_q     <= fin_d;
        end
    end

    assign so_data     = so_data_q;
    assign so_valid    = shift_st;
    assign busy        = state_q != IDLE;
    assign oem_dataout = dout_q;
    assign oem_addr    = addr_q;
    assign odd_wr      = odd_q;
    assign even_wr     = even_q;
    assign oem_finish  = fin_q;
endmodule

// File: tb/tb_sti_dac_gen.sv
// tb_sti_dac_gen: table, hand-written and random frames checked against a byte-stream reference model.
module tb_sti_dac_gen;
    localparam int NB  = 4;
    localparam int AW  = 5;
    localparam int CAP = NB << (AW + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0, pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
    logic [15:0]   pi_data = '0;
    logic [1:0]    pi_length = '0;
    logic          so_data, so_valid, busy, oem_finish;
    logic [7:0]    oem_dataout;
    logic [AW-1:0] oem_addr;
    logic [NB-1:0] odd_wr, even_wr;

    int vectors = 0, miscompares = 0, cyc = 0, fin_due = 1 << 30;
    int mk = 0, mn = 0;
    logic [7:0] macc = '0;

    typedef struct { int k; logic [7:0] data; int due; } wr_t;
    typedef struct { logic [NB-1:0] odd, even; logic [AW-1:0] addr; logic [7:0] data; } log_t;
    typedef struct { logic [15:0] d; logic [1:0] len; logic fill, msb, low; logic [31:0] frame; } vec_t;
    wr_t  exp_q[$];
    log_t wlog[$];
    vec_t tbl[8];

    sti_dac_gen #(.NUM_BANKS(NB), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid), .busy(busy), .oem_dataout(oem_dataout),
        .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] build(input logic [15:0] d, input logic [1:0] len, input logic fill, input logic low);
        int l = 8 * (int'(len) + 1);
        if (l == 8) return low ? 32'(d[15:8]) : 32'(d[7:0]);
        if (l == 16 || !fill) return 32'(d);
        return 32'(d) << (l - 16);
    endfunction

    task automatic model_bit(input logic b);
        macc = {macc[6:0], b};
        mn++;
        if (mn == 8) begin
            mn = 0;
            if (mk < CAP) exp_q.push_back('{mk, macc, cyc + 1});
            if (mk < CAP) mk++;
        end
    endtask

    // Each expected write carries the cycle its strobe must appear in.
    always @(negedge clk) begin : mon
        wr_t e;
        logic [NB-1:0] oh;
        logic od;
        if (!reset) begin
            if (odd_wr != 0 || even_wr != 0) wlog.push_back('{odd_wr, even_wr, oem_addr, oem_dataout});
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e  = exp_q.pop_front();
                oh = NB'(1) << (e.k / (2 * 2**AW));
                od = ((e.k % 2) ^ ((e.k / 8) % 2)) == 0;
                check($sformatf("odd_wr k=%0d", e.k), odd_wr, od ? oh : '0);
                check($sformatf("even_wr k=%0d", e.k), even_wr, od ? '0 : oh);
                check($sformatf("oem_addr k=%0d", e.k), oem_addr, (e.k / 2) % (2**AW));
                check($sformatf("oem_dataout k=%0d", e.k), oem_dataout, e.data);
            end else if (odd_wr != 0 || even_wr != 0)
                check($sformatf("unexpected strobe cyc=%0d", cyc), {odd_wr, even_wr}, 0);
            if ((cyc >= fin_due) != oem_finish) check("oem_finish timing", oem_finish, cyc >= fin_due);
        end
    end

    task automatic check_zero(input string nm);
        check({nm, " so_data"}, so_data, 0);
        check({nm, " so_valid"}, so_valid, 0);
        check({nm, " busy"}, busy, 0);
        check({nm, " oem_dataout"}, oem_dataout, 0);
        check({nm, " oem_addr"}, oem_addr, 0);
        check({nm, " odd_wr"}, odd_wr, 0);
        check({nm, " even_wr"}, even_wr, 0);
        check({nm, " oem_finish"}, oem_finish, 0);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        load  = 1'b0;
        exp_q.delete();
        wlog.delete();
        mk = 0;
        mn = 0;
        macc = '0;
        fin_due = 1 << 30;
        #1 check_zero(nm);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill, input logic msb,
                        input logic low, input logic last_f, input logic [31:0] frame, input string nm);
        int l = 8 * (int'(len) + 1);
        int w = 0;
        int t = 0;
        logic b = 1'b0;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({nm, " busy before load"}, busy, 0);
        pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = last_f;
        load = 1'b1;
        @(negedge clk);
        for (int i = 0; i < l; i++) begin
            if (i > 0) @(negedge clk);
            b = frame[msb ? l - 1 - i : i];
            check($sformatf("%s so_valid bit%0d", nm, i), so_valid, 1);
            check($sformatf("%s so_data bit%0d", nm, i), so_data, b);
            model_bit(b);
            t = cyc;
            load    = (i < l - 1) ? 1'($urandom) : 1'b0;
            pi_data = 16'($urandom);
            pi_end  = 1'($urandom);
        end
        @(negedge clk);
        check({nm, " so_valid after"}, so_valid, 0);
        check({nm, " so_data hold"}, so_data, b);
        check({nm, " busy after"}, busy, last_f);
        if (last_f) begin
            int np = 0;
`ifdef STI_DAC_GEN_PAD_EN
            while (mk < CAP) begin
                exp_q.push_back('{mk, 8'h00, t + 2 + np});
                mk++;
                np++;
            end
`endif
            fin_due = t + 2 + np;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic [1:0]  rl;
        logic        rf, rm, ro;
        int          w;
        tbl[0] = '{16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000A5C3};
        tbl[1] = '{16'h0001, 2'b11, 1'b0, 1'b0, 1'b0, 32'h00000001};
        tbl[2] = '{16'hBEEF, 2'b00, 1'b0, 1'b1, 1'b1, 32'h000000BE};
        tbl[3] = '{16'hBEEF, 2'b00, 1'b1, 1'b0, 1'b0, 32'h000000EF};
        tbl[4] = '{16'h1234, 2'b10, 1'b1, 1'b1, 1'b0, 32'h00123400};
        tbl[5] = '{16'h1234, 2'b10, 1'b0, 1'b0, 1'b1, 32'h00001234};
        tbl[6] = '{16'hCAFE, 2'b11, 1'b1, 1'b1, 1'b0, 32'hCAFE0000};
        tbl[7] = '{16'h8001, 2'b11, 1'b0, 1'b1, 1'b0, 32'h00008001};
        do_reset("reset");

        for (int i = 0; i < 8; i++)
            send(tbl[i].d, tbl[i].len, tbl[i].fill, tbl[i].msb, tbl[i].low, 1'b0, tbl[i].frame, $sformatf("tbl%0d", i));
        @(negedge clk);
        check("tbl write count", wlog.size(), 22);
        if (wlog.size() >= 2) begin
            check("k0 odd_wr", wlog[0].odd, 4'b0001);
            check("k0 data", wlog[0].data, 8'hA5);
            check("k1 even_wr", wlog[1].even, 4'b0001);
            check("k1 addr", wlog[1].addr, 0);
            check("k1 data", wlog[1].data, 8'hC3);
        end

        pi_data = 16'hFFFF; pi_length = 2'b10; pi_fill = 1'b1; pi_msb = 1'b1; pi_low = 1'b0; pi_end = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mid bit%0d", i), so_data, 1);
            @(negedge clk);
        end
        check("mid valid at bit5", so_valid, 1);
        do_reset("mid reset");
        @(negedge clk);
        check("post-reset strobes", {odd_wr, even_wr}, 0);
        check("post-reset so_valid", so_valid, 0);
        check("post-reset busy", busy, 0);

        for (int i = 1; i <= 9; i++)
            send(16'(i), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'(i), $sformatf("byte%0d", i));
        @(negedge clk);
        check("checker write count", wlog.size(), 9);
        if (wlog.size() >= 9) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("k%0d odd side", i), wlog[i].odd, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            check("k8 even_wr", wlog[8].even, 4'b0001);
            check("k8 odd_wr", wlog[8].odd, 4'b0000);
            check("k8 addr", wlog[8].addr, 4);
            check("k8 data", wlog[8].data, 8'h09);
        end

        send(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000A5C3, "end");
        w = 0;
        while (!oem_finish && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("finish reached", oem_finish, 1);
        load = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("finish ignores load so_valid", so_valid, 0);
            check("finish held", oem_finish, 1);
            check("finish strobes", {odd_wr, even_wr}, 0);
        end
        load = 1'b0;

        do_reset("overflow reset");
        while (mk < CAP || mn != 0) begin
            rd = 16'($urandom); rl = 2'($urandom); rf = 1'($urandom); rm = 1'($urandom); ro = 1'($urandom);
            send(rd, rl, rf, rm, ro, 1'b0, build(rd, rl, rf, ro), "rnd");
        end
        for (int i = 0; i < 4; i++) begin
            rd = 16'($urandom); rl = 2'($urandom); rf = 1'($urandom); rm = 1'($urandom); ro = 1'($urandom);
            send(rd, rl, rf, rm, ro, i == 3, build(rd, rl, rf, ro), "ovf");
        end
        w = 0;
        while (!oem_finish && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("overflow finish reached", oem_finish, 1);
        check("overflow write count", wlog.size(), CAP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sti_dac_gen.md
STI_DAC_GEN -- requirements
Module: sti_dac_gen

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of odd/even memory bank pairs (power of two, 1..8).
REQ-002 SHALL have parameter ADDR_W, default 5, address width of each odd or even bank (2^ADDR_W bytes each).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  frame load request, sampled only when busy=0.
REQ-006 SHALL have port pi_data  input  16  parallel payload.
REQ-007 SHALL have port pi_length  input  2  frame length: 00=8, 01=16, 10=24, 11=32 bits.
REQ-008 SHALL have ports pi_fill, pi_msb, pi_low, pi_end  input  1 each  fill side, MSB-first, high-byte select, last frame.
REQ-009 SHALL have ports so_data, so_valid, busy  output  1 each  serial bit, bit valid, transmitter occupied.
REQ-010 SHALL have ports oem_dataout  output  8, oem_addr  output  ADDR_W  byte and bank address for writes.
REQ-011 SHALL have ports odd_wr, even_wr  output  NUM_BANKS each  one-hot write strobes; oem_finish  output  1  image done.

Function
REQ-012 FSM states: IDLE, SHIFT, PAD, FINISH; exit from reset to IDLE.
REQ-013 IDLE with load=1: latch frame and pi_msb/pi_end, go to SHIFT, busy=1 next cycle; load ignored in every other state.
REQ-014 Frame build: L=8 -> pi_low ? pi_data[15:8] : pi_data[7:0]; L=16 -> pi_data; L=24/32 -> pi_fill=1: pi_data in MSBs, zeros below; pi_fill=0: zeros above, pi_data in LSBs.
REQ-015 SHIFT: exactly L consecutive cycles of so_valid=1, first bit in the cycle after load; pi_msb=1 sends frame bit L-1 first, else bit 0 first.
REQ-016 After the L-th bit: SHIFT->IDLE (busy=0) if latched pi_end=0, else ->PAD; so_valid=0 and so_data holds last value outside SHIFT.
REQ-017 Deserializer: bits packed into bytes, first received bit = byte bit 7; global byte counter k (0..CAP-1), CAP=NUM_BANKS*2^(ADDR_W+1).
REQ-018 Byte write: one-cycle strobe in the cycle after the byte's 8th valid bit; oem_dataout/oem_addr valid in the same cycle.
REQ-019 Mapping: bank=k[ADDR_W+1 +: log2(NUM_BANKS)], oem_addr=k[ADDR_W:1]; k[0]^k[3]=0 -> odd_wr[bank], else even_wr[bank] (8-byte checkerboard).
REQ-020 At most one write strobe bit high per cycle; k increments once per write.
REQ-021 Overflow: once k=CAP, further bytes are discarded, no strobes, k saturates; transmission continues unaffected.
REQ-022 Back-to-back: load accepted in the cycle busy falls; last-byte write of prior frame overlapping the new frame's first bit is legal.
REQ-023 FINISH: all strobes 0, oem_finish=1 held until reset; FINISH is terminal.

Reset
REQ-024 Asynchronous reset SHALL force: state IDLE, k=0, so_data=0, so_valid=0, busy=0, oem_dataout=0, oem_addr=0, odd_wr=0, even_wr=0, oem_finish=0.
REQ-025 Reset mid-frame or mid-pad SHALL abandon the operation; no strobe in the cycle after reset release.

Configuration
REQ-026 Macro STI_DAC_GEN_PAD_EN defined: PAD writes 0x00 one byte per cycle at consecutive k until k=CAP, then FINISH next cycle.
REQ-027 Macro STI_DAC_GEN_PAD_EN undefined: PAD state absent; after the last frame's final write, FINISH next cycle, oem_finish=1 one cycle after the last strobe.

Verification
REQ-028 load, pi_length=01, pi_data=16'hA5C3, pi_msb=1 -> so_valid 16 cycles, bits 1010010111000011; odd_wr[0] with 0xA5 addr 0, then even_wr[0] with 0xC3 addr 0.
REQ-029 pi_length=11, pi_fill=0, pi_msb=0, pi_data=16'h0001 -> first so_data=1, then 31 zeros; 4 bytes 0x80,0x00,0x00,0x00 at k=0..3.
REQ-030 8 frames of 8 bits 0x01..0x08 -> k=0..7 alternate odd/even from odd; next byte k=8 goes to even_wr[0] addr 4.
REQ-031 PAD_EN, single 16-bit frame pi_end=1, defaults -> 254 zero writes after data, banks 0..3 all strobed, oem_finish=1 one cycle after k=255 write.
REQ-032 Reset asserted at bit 5 of a 24-bit frame -> all outputs 0 next edge; subsequent frame writes start at k=0.
REQ-033 NUM_BANKS=2, ADDR_W=4, 33 16-bit frames -> 64 writes, byte 64 onward suppressed, no strobes beyond bank 1.
